// File: rtl/compuertas_pkg.sv
// Shared definitions for the logic-gate self-test checker: gate bit positions,
// FSM state encoding, the golden gate function and a small popcount helper.
package compuertas_pkg;

    localparam int GATE_AND  = 0;
    localparam int GATE_NAND = 1;
    localparam int GATE_OR   = 2;
    localparam int GATE_NOR  = 3;
    localparam int GATE_NOT  = 4;
    localparam int GATE_XOR  = 5;
    localparam int GATE_XNOR = 6;
    localparam int NUM_GATES = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_e;

    // The NOT gate inverts input a; b does not affect it.
    function automatic logic [NUM_GATES-1:0] golden(input logic a, input logic b);
        logic [NUM_GATES-1:0] g;
        g            = '0;
        g[GATE_AND]  = a & b;
        g[GATE_NAND] = ~(a & b);
        g[GATE_OR]   = a | b;
        g[GATE_NOR]  = ~(a | b);
        g[GATE_NOT]  = ~a;
        g[GATE_XOR]  = a ^ b;
        g[GATE_XNOR] = ~(a ^ b);
        return g;
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_GATES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_GATES; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/compuertas_checker_golden.sv
// Combinational reference model: expected seven gate outputs for inputs a,b.
module compuertas_golden
    import compuertas_pkg::*;
(
    input  logic                 i_a,
    input  logic                 i_b,
    output logic [NUM_GATES-1:0] o_expected
);

    assign o_expected = golden(i_a, i_b);

endmodule

// File: rtl/compuertas_checker.sv
// Self-test sequencer for the 7-output gate block: drives a,b through the truth
// table, scores the gate outputs and reports mask/count/pass. COMPUERTAS_CHK_LOG_EN adds first-fail logging.
module compuertas_checker
    import compuertas_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int LOOPS         = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 a_o,
    output logic                 b_o,
    input  logic [NUM_GATES-1:0] gates_i,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NUM_GATES-1:0] err_mask,
    output logic [7:0]           err_count
`ifdef COMPUERTAS_CHK_LOG_EN
    ,
    output logic                 first_fail_vld,
    output logic [1:0]           first_fail_vec
`endif
);

    localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);
    localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? SW'(SETTLE_CYCLES - 1) : '0;

    state_e                 r_state;
    state_e                 w_next_state;
    logic [1:0]             r_vec;
    logic [LW-1:0]          r_loop;
    logic [SW-1:0]          r_settle_cnt;
    logic [NUM_GATES-1:0]   r_err_mask;
    logic [7:0]             r_err_count;
    logic                   r_pass;
    logic [NUM_GATES-1:0]   w_expected;
    logic [NUM_GATES-1:0]   w_mism;
    logic [8:0]             w_count_sum;

    compuertas_golden u_golden (
        .i_a        (r_vec[1]),
        .i_b        (r_vec[0]),
        .o_expected (w_expected)
    );

    assign w_mism      = gates_i ^ w_expected;
    assign w_count_sum = {1'b0, r_err_count} + {5'b00000, popcount(w_mism)};

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: default assigned first so no path through the case can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_DRIVE;
            ST_DRIVE:  w_next_state = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;
            ST_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_next_state = ST_CHECK;
            ST_CHECK:  begin
                if (r_vec != 2'd3 || r_loop != LOOP_LAST) w_next_state = ST_DRIVE;
                else                                      w_next_state = ST_DONE;
            end
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec        <= '0;
            r_loop       <= '0;
            r_settle_cnt <= '0;
            r_err_mask   <= '0;
            r_err_count  <= '0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_vec       <= '0;
                        r_loop      <= '0;
                        r_err_mask  <= '0;
                        r_err_count <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                ST_DRIVE:  r_settle_cnt <= '0;
                ST_SETTLE: r_settle_cnt <= r_settle_cnt + SW'(1);
                ST_CHECK: begin
                    r_err_mask  <= r_err_mask | w_mism;
                    r_err_count <= w_count_sum[8] ? 8'hFF : w_count_sum[7:0];
                    // vec wraps 3->0 naturally; loop only advances while passes remain.
                    r_vec <= r_vec + 2'd1;
                    if (r_vec == 2'd3 && r_loop != LOOP_LAST) r_loop <= r_loop + LW'(1);
                end
                ST_DONE:   r_pass <= (r_err_mask == '0);
                default: ;
            endcase
        end
    end

`ifdef COMPUERTAS_CHK_LOG_EN
    logic       r_ff_vld;
    logic [1:0] r_ff_vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ff_vld <= 1'b0;
            r_ff_vec <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_ff_vld <= 1'b0;
            r_ff_vec <= '0;
        end else if (r_state == ST_CHECK && w_mism != '0 && !r_ff_vld) begin
            r_ff_vld <= 1'b1;
            r_ff_vec <= r_vec;
        end
    end

    assign first_fail_vld = r_ff_vld;
    assign first_fail_vec = r_ff_vec;
`endif

    assign a_o       = r_vec[1];
    assign b_o       = r_vec[0];
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign pass      = r_pass;
    assign err_mask  = r_err_mask;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_compuertas_checker.sv
// Directed bench for compuertas_checker: three instances (S=1/L=1, S=1/L=3,
// S=0/L=10) driven by a behavioural gate block with selectable faults.
module tb_compuertas_checker;

    typedef enum int {F_GOOD, F_XOR_SA0, F_AND_INV, F_ALL_INV, F_NOR_SA1} fault_e;

    localparam int PHASE = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    fault_e fault = F_GOOD;

    logic       a1, b1, busy1, done1, pass1;
    logic [6:0] g1, mask1;
    logic [7:0] cnt1;
    logic       a3, b3, busy3, done3, pass3;
    logic [6:0] g3, mask3;
    logic [7:0] cnt3;
    logic       a10, b10, busy10, done10, pass10;
    logic [6:0] g10, mask10;
    logic [7:0] cnt10;
`ifdef COMPUERTAS_CHK_LOG_EN
    logic       ffv1, ffv3, ffv10;
    logic [1:0] ffc1, ffc3, ffc10;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int d1_first, d1_second, d1_pulses, d3_done, d10_done;
    logic       s_busy [0:PHASE];
    logic       s_done [0:PHASE];
    logic       s_pass [0:PHASE];
    logic [1:0] s_ab   [0:PHASE];
    logic [6:0] s_mask [0:PHASE];
    logic [7:0] s_cnt  [0:PHASE];

    always #5 clk = ~clk;

    function automatic logic [6:0] gate_model(input logic a, input logic b, input fault_e f);
        logic [6:0] g;
        g = {~(a ^ b), a ^ b, ~a, ~(a | b), a | b, ~(a & b), a & b};
        case (f)
            F_XOR_SA0: g[5] = 1'b0;
            F_AND_INV: g[0] = ~g[0];
            F_ALL_INV: g    = ~g;
            F_NOR_SA1: g[3] = 1'b1;
            default: ;
        endcase
        return g;
    endfunction

    assign g1  = gate_model(a1, b1, fault);
    assign g3  = gate_model(a3, b3, fault);
    assign g10 = gate_model(a10, b10, fault);

    compuertas_checker #(.SETTLE_CYCLES(1), .LOOPS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a_o(a1), .b_o(b1), .gates_i(g1),
        .busy(busy1), .done(done1), .pass(pass1), .err_mask(mask1), .err_count(cnt1)
`ifdef COMPUERTAS_CHK_LOG_EN
        , .first_fail_vld(ffv1), .first_fail_vec(ffc1)
`endif
    );

    compuertas_checker #(.SETTLE_CYCLES(1), .LOOPS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .a_o(a3), .b_o(b3), .gates_i(g3),
        .busy(busy3), .done(done3), .pass(pass3), .err_mask(mask3), .err_count(cnt3)
`ifdef COMPUERTAS_CHK_LOG_EN
        , .first_fail_vld(ffv3), .first_fail_vec(ffc3)
`endif
    );

    compuertas_checker #(.SETTLE_CYCLES(0), .LOOPS(10)) dut10 (
        .clk(clk), .rst(rst), .start(start), .a_o(a10), .b_o(b10), .gates_i(g10),
        .busy(busy10), .done(done10), .pass(pass10), .err_mask(mask10), .err_count(cnt10)
`ifdef COMPUERTAS_CHK_LOG_EN
        , .first_fail_vld(ffv10), .first_fail_vec(ffc10)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start is raised before edge 0; index cyc is the cycle following edge cyc-1.
    // Start stays high through cycle hold_cyc, pulses again in pulse_cyc, rst rises in rst_cyc.
    task automatic run_phase(input fault_e f, input int hold_cyc, input int pulse_cyc, input int rst_cyc);
        fault     = f;
        d1_first  = 0;
        d1_second = 0;
        d1_pulses = 0;
        d3_done   = 0;
        d10_done  = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= PHASE; cyc++) begin
            @(negedge clk);
            s_busy[cyc] = busy1;
            s_done[cyc] = done1;
            s_pass[cyc] = pass1;
            s_ab[cyc]   = {a1, b1};
            s_mask[cyc] = mask1;
            s_cnt[cyc]  = cnt1;
            if (done1) begin
                d1_pulses++;
                if (d1_first == 0)       d1_first  = cyc;
                else if (d1_second == 0) d1_second = cyc;
            end
            if (done3 && d3_done == 0)   d3_done  = cyc;
            if (done10 && d10_done == 0) d10_done = cyc;
            start = (cyc <= hold_cyc) || (cyc == pulse_cyc);
            rst   = (cyc == rst_cyc);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic check_accept(input string tag);
        check({tag, "_c1_busy"}, 32'(s_busy[1]), 32'd1);
        check({tag, "_c1_cnt"},  32'(s_cnt[1]),  32'd0);
        check({tag, "_c1_mask"}, 32'(s_mask[1]), 32'd0);
        check({tag, "_c1_pass"}, 32'(s_pass[1]), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_pass", 32'(pass1), 32'd0);
        check("rst_mask", 32'(mask1), 32'd0);
        check("rst_cnt",  32'(cnt1),  32'd0);
        check("rst_ab",   32'({a1, b1}), 32'd0);

        // Good gates; a stray start in cycle 5 must be ignored.
        run_phase(F_GOOD, 0, 5, 0);
        check_accept("good");
        check("good_done_cyc",  32'(d1_first),  32'd13);
        check("good_done_once", 32'(d1_pulses), 32'd1);
        check("good_ab_c1",  32'(s_ab[1]),  32'd0);
        check("good_ab_c4",  32'(s_ab[4]),  32'd1);
        check("good_ab_c7",  32'(s_ab[7]),  32'd2);
        check("good_ab_c10", 32'(s_ab[10]), 32'd3);
        check("good_busy_c13", 32'(s_busy[13]), 32'd1);
        check("good_busy_c14", 32'(s_busy[14]), 32'd0);
        check("good_done_c12", 32'(s_done[12]), 32'd0);
        check("good_pass", 32'(pass1), 32'd1);
        check("good_mask", 32'(mask1), 32'd0);
        check("good_cnt",  32'(cnt1),  32'd0);
        check("good_l3_done_cyc",  32'(d3_done),  32'd37);
        check("good_l3_pass",      32'(pass3),    32'd1);
        check("good_s0_done_cyc",  32'(d10_done), 32'd81);
        check("good_s0_pass",      32'(pass10),   32'd1);

        // XOR stuck-at-0: mismatches on vectors 01 and 10.
        run_phase(F_XOR_SA0, 0, 0, 0);
        check_accept("xor");
        check("xor_mask", 32'(mask1), 32'h20);
        check("xor_cnt",  32'(cnt1),  32'd2);
        check("xor_pass", 32'(pass1), 32'd0);
        check("xor_l3_cnt",  32'(cnt3),  32'd6);
        check("xor_s0_cnt",  32'(cnt10), 32'd20);

        // AND inverted: one mismatch per vector.
        run_phase(F_AND_INV, 0, 0, 0);
        check_accept("and");
        check("and_cnt",     32'(cnt1),  32'd4);
        check("and_l3_cnt",  32'(cnt3),  32'd12);
        check("and_l3_mask", 32'(mask3), 32'h01);
        check("and_l3_pass", 32'(pass3), 32'd0);
        check("and_s0_cnt",  32'(cnt10), 32'd40);

        // Every output inverted: 28 per pass; ten passes saturate.
        run_phase(F_ALL_INV, 0, 0, 0);
        check("inv_cnt",      32'(cnt1),   32'd28);
        check("inv_mask",     32'(mask1),  32'h7F);
        check("inv_l3_cnt",   32'(cnt3),   32'd84);
        check("inv_s0_cnt",   32'(cnt10),  32'd255);
        check("inv_s0_mask",  32'(mask10), 32'h7F);

        // Start held high: second run accepted after one IDLE cycle.
        run_phase(F_GOOD, 14, 0, 0);
        check("held_done1",  32'(d1_first),  32'd13);
        check("held_idle14", 32'(s_busy[14]), 32'd0);
        check("held_done2",  32'(d1_second), 32'd27);
        check("held_pass",   32'(pass1),     32'd1);

        // Reset in cycle 6 discards the run.
        run_phase(F_ALL_INV, 0, 0, 6);
        check("rstrun_cnt_c6",  32'(s_cnt[6]),  32'd7);
        check("rstrun_busy_c7", 32'(s_busy[7]), 32'd0);
        check("rstrun_ab_c7",   32'(s_ab[7]),   32'd0);
        check("rstrun_cnt_c7",  32'(s_cnt[7]),  32'd0);
        check("rstrun_no_done", 32'(d1_pulses), 32'd0);
        check("rstrun_pass",    32'(pass1),     32'd0);

        run_phase(F_GOOD, 0, 0, 0);
        check("after_rst_done_cyc", 32'(d1_first), 32'd13);
        check("after_rst_pass",     32'(pass1),    32'd1);

`ifdef COMPUERTAS_CHK_LOG_EN
        // NOR stuck-at-1: fails on 01, 10, 11; first failure at 01.
        run_phase(F_NOR_SA1, 0, 0, 0);
        check("log_cnt",     32'(cnt1),  32'd3);
        check("log_ffv",     32'(ffv1),  32'd1);
        check("log_ffvec",   32'(ffc1),  32'd1);
        check("log_s0_ffv",  32'(ffv10), 32'd1);
        check("log_s0_ffvec",32'(ffc10), 32'd1);
        check("log_l3_ffvec",32'(ffc3),  32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
